// File: rtl/mmio_uart_tx_queue_pkg.sv
// Shared definitions for the memory-mapped UART transmit queue:
// register offsets, STATUS bit layout and TX state encoding.
package mmio_uart_tx_queue_pkg;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS register bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

  // CTRL register bit positions
  localparam int CTRL_FLUSH = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  // Assemble the STATUS word; all unlisted bits read as zero.
  function automatic logic [31:0] pack_status(
    input logic                  full,
    input logic                  empty,
    input logic                  busy,
    input logic                  ovf,
    input logic [STAT_CNT_W-1:0] cnt
  );
    logic [31:0] s;
    s                              = '0;
    s[STAT_FULL]                   = full;
    s[STAT_EMPTY]                  = empty;
    s[STAT_BUSY]                   = busy;
    s[STAT_OVF]                    = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_queue_sync_fifo.sv
// Single-clock byte FIFO with push/pop/flush. Flush has priority over
// a same-cycle push; a push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle, otherwise it is dropped and
// reported on the drop output.
module mmio_uart_tx_queue_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_acc;
  logic             pop_acc;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign pop_acc  = pop && !empty;
  assign push_acc = push && !flush && (!full || pop_acc);
  assign drop     = push && !flush && !push_acc;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_acc) - CW'(pop_acc);
    end
  end

endmodule

// File: rtl/mmio_uart_tx_queue.sv
// Memory-mapped UART transmit queue. Decodes stores in a 16-byte window,
// buffers DATA bytes in a FIFO and drains them to the UART through a
// start/busy handshake with a busy-rise timeout.
module mmio_uart_tx_queue
  import mmio_uart_tx_queue_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        memwrite_in,
  input  logic [2:0]  func3_in,
  output logic [31:0] rdata_out,
  output logic        hit_out,
  input  logic        tx_busy_in,
  output logic        tx_start_out,
  output logic [7:0]  tx_data_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [1:0]    offset;
  logic          wr_en;
  logic          push;
  logic          flush;
  logic          ovf_clr;
  logic          overflow;
  logic          launch;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_drop;
  tx_state_e     state;
  tx_state_e     state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  // Access size and upper data bits do not affect this peripheral.
  logic unused_bits;
  assign unused_bits = ^{func3_in, wdata_in[31:8], addr_in[1:0]};

  assign hit_out = (addr_in[31:4] == BASE_ADDR[31:4]);
  assign offset  = addr_in[3:2];
  assign wr_en   = memwrite_in && hit_out;
  assign push    = wr_en && (offset == OFF_DATA);
  assign ovf_clr = wr_en && (offset == OFF_STATUS);
  assign flush   = wr_en && (offset == OFF_CTRL) && wdata_in[CTRL_FLUSH];

  mmio_uart_tx_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wdata_in[7:0]),
    .pop       (launch),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // Sticky overflow: set by a dropped push, cleared by any STATUS write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // TX next-state: launch from IDLE, wait for busy rise (with timeout), wait for busy fall.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (!fifo_empty && !tx_busy_in) begin
          launch    = 1'b1;
          state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_in) begin
          state_nxt = ST_WAIT_DONE;
          timer_nxt = '0;
        end else if (timer == TMO_LAST) begin
          // No busy response: treat the byte as sent and move on.
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_in) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // TX state register; start pulse and launched byte are registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      tx_start_out <= 1'b0;
      tx_data_out  <= 8'h00;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      tx_start_out <= launch;
      if (launch) begin
        tx_data_out <= fifo_head;
      end
    end
  end

  // Combinational register read; only STATUS returns non-zero data.
  always_comb begin
    rdata_out = '0;
    if (hit_out && (offset == OFF_STATUS)) begin
      rdata_out = pack_status(fifo_full, fifo_empty, tx_busy_in, overflow,
                              STAT_CNT_W'(fifo_count));
    end
  end

endmodule
